// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared command encoding, latency check and default reset image
package reg_file_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      WRITE   = 2'b01,
      READ    = 2'b10,
      ILLEGAL = 2'b11
   } cmd_e;

   localparam int MAX_IMG_W = 4096;

   function automatic cmd_e decode(logic wr_en, logic rd_en);
      return cmd_e'({rd_en, wr_en});
   endfunction

   function automatic bit rd_lat_ok(int lat);
      return lat == 1 || lat == 2;
   endfunction

   function automatic logic [MAX_IMG_W-1:0] default_rst_vals(int data_w);
      logic [MAX_IMG_W-1:0] v;
      v = '0;
      v[2*data_w +: 8] = 8'h81;
      v[3*data_w +: 8] = 8'h20;
      return v;
   endfunction

endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: command/response bus between the decoder and the register file
interface reg_file_if #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 4,
   parameter int NUM_CFG = 4
);
   logic                      Addr_En;
   logic [ADDR_W-1:0]         Address;
   logic                      WrEn;
   logic                      RdEn;
   logic [DATA_W-1:0]         WrData;
   logic [DATA_W-1:0]         WrMask;
   logic                      Lock;
   logic [DATA_W-1:0]         RdData;
   logic                      RdData_Valid;
   logic                      Err;
   logic [NUM_CFG*DATA_W-1:0] CFG_Regs;

   modport master (
      output Addr_En, Address, WrEn, RdEn, WrData, WrMask, Lock,
      input  RdData, RdData_Valid, Err, CFG_Regs
   );

   modport slave (
      input  Addr_En, Address, WrEn, RdEn, WrData, WrMask, Lock,
      output RdData, RdData_Valid, Err, CFG_Regs
   );
endinterface

// File: rtl/reg_file_rd_pipe.sv
// reg_file_rd_pipe: 1- or 2-stage delay line for read data, valid and error
module reg_file_rd_pipe #(
   parameter int DATA_W = 8,
   parameter int LAT    = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_v,
   input  logic              in_e,
   input  logic [DATA_W-1:0] in_d,
   output logic              out_v,
   output logic              out_e,
   output logic [DATA_W-1:0] out_d
);
   logic [LAT-1:0]        v_q, e_q, v_in, e_in;
   logic [LAT*DATA_W-1:0] d_q, d_in;

   assign v_in  = LAT'({v_q, in_v});
   assign e_in  = LAT'({e_q, in_v & in_e});
   assign d_in  = (LAT*DATA_W)'({d_q, in_d});
   assign out_v = v_q[LAT-1];
   assign out_e = e_q[LAT-1];
   assign out_d = d_q[(LAT-1)*DATA_W +: DATA_W];

   // shift valid/err every cycle; each data stage only loads when a read passes, so the output holds the last read
   always_ff @(posedge CLK) begin
      if (RST) begin
         v_q <= '0;
         e_q <= '0;
         d_q <= '0;
      end else begin
         v_q <= v_in;
         e_q <= e_in;
         for (int i = 0; i < LAT; i++)
            if (v_in[i]) d_q[i*DATA_W +: DATA_W] <= d_in[i*DATA_W +: DATA_W];
      end
   end
endmodule

// File: rtl/reg_file_pipe.sv
// reg_file_pipe: masked, lockable register file with latched address and pipelined reads
module reg_file_pipe
   import reg_file_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int NUM_CFG = 4,
   parameter int RD_LAT  = 1,
   parameter logic [DEPTH*DATA_W-1:0] RST_VALS = (DEPTH*DATA_W)'(default_rst_vals(DATA_W))
) (
   input logic       CLK,
   input logic       RST,
   reg_file_if.slave bus
);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] NCFG_L  = (ADDR_W+1)'(NUM_CFG);

   if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
      $error("reg_file_pipe: RD_LAT must be 1 or 2");
   end

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data;
   logic              in_range, locked, wr_err_q, rd_err;
   cmd_e              cmd;

   assign cmd      = decode(bus.WrEn, bus.RdEn);
   assign in_range = {1'b0, addr_q} < DEPTH_L;
   assign locked   = bus.Lock && ({1'b0, addr_q} < NCFG_L);
   assign rd_data  = in_range ? mem[addr_q] : '0;
   assign bus.Err  = wr_err_q | rd_err;

   // address register; commands in the same cycle still see the old value
   always_ff @(posedge CLK) begin
      if (RST) addr_q <= '0;
      else if (bus.Addr_En) addr_q <= bus.Address;
   end

   // storage with per-bit masked writes, rejected when out of range or locked
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VALS[i*DATA_W +: DATA_W];
      end else if (cmd == WRITE && in_range && !locked) begin
         mem[addr_q] <= (mem[addr_q] & ~bus.WrMask) | (bus.WrData & bus.WrMask);
      end
   end

   // error pulse for conflicting commands and rejected writes, one cycle after issue
   always_ff @(posedge CLK) begin
      wr_err_q <= !RST && (cmd == ILLEGAL || (cmd == WRITE && (!in_range || locked)));
   end

   reg_file_rd_pipe #(.DATA_W(DATA_W), .LAT(RD_LAT)) u_rd_pipe (
      .CLK   (CLK),
      .RST   (RST),
      .in_v  (cmd == READ),
      .in_e  (!in_range),
      .in_d  (rd_data),
      .out_v (bus.RdData_Valid),
      .out_e (rd_err),
      .out_d (bus.RdData)
   );

   for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg
      assign bus.CFG_Regs[k*DATA_W +: DATA_W] = mem[k];
   end
endmodule
